// File: rtl/serial_record_loader.sv
// serial_record_loader: deserialises a lane-wide bitstream into words and packs feat+1 words per record write
// Ports: CLK/RST clock and sync active-high reset; start/feat/data_points launch a load;
//        S_valid/S serial beats; wr_en/wr_addr/wr_data one-cycle record write; busy in LOAD, done_ in DONE.
module serial_record_loader #(
  parameter int WORD_WIDTH   = 16,
  parameter int MAX_FEATURES = 15,
  parameter int ADDR_WIDTH   = 12,
  parameter int LANES        = 1,
  parameter int MSB_FIRST    = 0,
  parameter int FW           = $clog2(MAX_FEATURES + 1)
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   start,
  input  logic [FW-1:0]                          feat,
  input  logic [ADDR_WIDTH-1:0]                  data_points,
  input  logic                                   S_valid,
  input  logic [LANES-1:0]                       S,
  output logic                                   wr_en,
  output logic [ADDR_WIDTH-1:0]                  wr_addr,
  output logic [WORD_WIDTH*(MAX_FEATURES+1)-1:0] wr_data,
  output logic                                   busy,
  output logic                                   done_
);
  localparam int BEATS = WORD_WIDTH / LANES;
  localparam int BCW   = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int RW    = WORD_WIDTH * (MAX_FEATURES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t                state_q;
  logic [FW-1:0]         feat_q, wcnt_q, slot, feat_c;
  logic [ADDR_WIDTH-1:0] dp_q, rec_q, wr_addr_q;
  logic [BCW-1:0]        bcnt_q, pos;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [RW-1:0]         buf_q, buf_d, wr_data_q;
  logic                  fin_q, wr_en_q, busy_q, done_q, word_done;
  always_comb begin
    feat_c    = (int'(feat) > MAX_FEATURES) ? FW'(MAX_FEATURES) : feat;
    pos       = (MSB_FIRST != 0) ? BCW'(BEATS - 1) - bcnt_q : bcnt_q;
    word_done = bcnt_q == BCW'(BEATS - 1);
    slot      = feat_q - wcnt_q;
    word_d    = word_q;
    // every beat position is rewritten within a word, so stale bits never survive
    for (int b = 0; b < BEATS; b++)
      if (BCW'(b) == pos) word_d[b*LANES +: LANES] = S;
    buf_d = buf_q;
    for (int k = 0; k <= MAX_FEATURES; k++)
      if (FW'(k) == slot) buf_d[k*WORD_WIDTH +: WORD_WIDTH] = word_d;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      feat_q    <= '0;
      dp_q      <= '0;
      bcnt_q    <= '0;
      wcnt_q    <= '0;
      rec_q     <= '0;
      word_q    <= '0;
      buf_q     <= '0;
      fin_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= LOAD;
          feat_q  <= feat_c;
          dp_q    <= data_points;
          bcnt_q  <= '0;
          wcnt_q  <= '0;
          rec_q   <= '0;
          word_q  <= '0;
          buf_q   <= '0;
          fin_q   <= 1'b0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        LOAD: if (fin_q) begin
          // final write is on the bus this cycle; leave LOAD so busy/done_ move one cycle later
          state_q <= DONE;
          fin_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else if (S_valid) begin
          word_q <= word_d;
          bcnt_q <= word_done ? '0 : bcnt_q + 1'b1;
          if (word_done && wcnt_q == feat_q) begin
            wcnt_q    <= '0;
            buf_q     <= '0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= rec_q;
            wr_data_q <= buf_d;
            rec_q     <= rec_q + 1'b1;
            fin_q     <= rec_q == dp_q;
          end else if (word_done) begin
            wcnt_q <= wcnt_q + 1'b1;
            buf_q  <= buf_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done_   = done_q;
endmodule

// File: tb/tb_serial_record_loader.sv
// tb_serial_record_loader: directed checks of record packing, write timing, stalls, reset and restart
module tb_serial_record_loader;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic         start0 = 0, v0 = 0, we0, busy0, done0;
  logic [3:0]   feat0 = 0;
  logic [11:0]  dp0 = 0, wa0;
  logic [0:0]   s0 = 0;
  logic [255:0] wd0;
  logic         start1 = 0, v1 = 0, we1, busy1, done1;
  logic [3:0]   feat1 = 0, s1 = 0;
  logic [11:0]  dp1 = 0, wa1;
  logic [255:0] wd1;
  logic         start2 = 0, v2 = 0, we2, busy2, done2;
  logic [3:0]   feat2 = 0;
  logic [11:0]  dp2 = 0, wa2;
  logic [0:0]   s2 = 0;
  logic [127:0] wd2;
  serial_record_loader u0 (.CLK(clk), .RST(rst), .start(start0), .feat(feat0), .data_points(dp0),
    .S_valid(v0), .S(s0), .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .busy(busy0), .done_(done0));
  serial_record_loader #(.LANES(4), .MSB_FIRST(1)) u1 (.CLK(clk), .RST(rst), .start(start1), .feat(feat1),
    .data_points(dp1), .S_valid(v1), .S(s1), .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .busy(busy1), .done_(done1));
  serial_record_loader #(.MAX_FEATURES(7), .FW(4)) u2 (.CLK(clk), .RST(rst), .start(start2), .feat(feat2),
    .data_points(dp2), .S_valid(v2), .S(s2), .wr_en(we2), .wr_addr(wa2), .wr_data(wd2), .busy(busy2), .done_(done2));
  int ec = 0, t0 = 0, dcyc = -1, ncmp = 0, nfail = 0;
  int qc[$];
  logic [11:0] qa[$];
  logic [255:0] qd[$];
  logic pd0 = 0, pd1 = 0, pd2 = 0;
  always @(posedge clk) ec <= ec + 1;
  always @(negedge clk) begin
    if (we0) begin qc.push_back(ec); qa.push_back(wa0); qd.push_back(wd0); end
    if (we1) begin qc.push_back(ec); qa.push_back(wa1); qd.push_back(wd1); end
    if (we2) begin qc.push_back(ec); qa.push_back(wa2); qd.push_back({128'b0, wd2}); end
    if ((done0 && !pd0) || (done1 && !pd1) || (done2 && !pd2)) dcyc = ec;
    pd0 = done0; pd1 = done1; pd2 = done2;
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [255:0] rec_exp(input logic [15:0] base, input int f);
    logic [255:0] r = '0;
    for (int k = 0; k <= f; k++) r[k*16 +: 16] = base + 16'(k);
    return r;
  endfunction
  task automatic tick; @(posedge clk); #1; endtask
  task automatic clearq; qc.delete(); qa.delete(); qd.delete(); endtask
  task automatic go0(input logic [3:0] f, input logic [11:0] d);
    start0 = 1; feat0 = f; dp0 = d; t0 = ec; tick; start0 = 0;
  endtask
  task automatic word0(input logic [15:0] w, input int sb, input int sn);
    for (int b = 0; b < 16; b++) begin
      if (b == sb) begin v0 = 0; repeat (sn) tick; end
      v0 = 1; s0 = w[b]; tick;
    end
    v0 = 0;
  endtask
  task automatic rec0(input logic [15:0] base, input int f, input int sslot, input int sb, input int sn);
    for (int k = f; k >= 0; k--) word0(base + 16'(k), k == sslot ? sb : -1, sn);
  endtask
  task automatic word2(input logic [15:0] w, input bit pulse);
    for (int b = 0; b < 16; b++) begin
      if (pulse && b == 0) begin start2 = 1; feat2 = 1; dp2 = 3; end
      v2 = 1; s2 = w[b]; tick; start2 = 0;
    end
    v2 = 0;
  endtask
  initial begin
    repeat (3) tick;
    chk("rst_wr_en", we0, 0);
    chk("rst_wr_addr", wa0, 0);
    chk("rst_wr_data", wd0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    rst = 0; tick;
    // two records, LSB-first, no stalls; trailing beats after the last write are ignored
    go0(5, 1);
    chk("t1_busy", busy0, 1);
    chk("t1_done_low", done0, 0);
    rec0(16'h0001, 5, -1, -1, 0);
    rec0(16'h0101, 5, -1, -1, 0);
    v0 = 1; s0 = 1; repeat (3) tick; v0 = 0; tick;
    chk("t1_nwr", qc.size(), 2);
    chk("t1_cyc0", qc[0], t0 + 97);
    chk("t1_addr0", qa[0], 0);
    chk("t1_data0", qd[0], rec_exp(16'h0001, 5));
    chk("t1_cyc1", qc[1], t0 + 193);
    chk("t1_addr1", qa[1], 1);
    chk("t1_data1", qd[1], rec_exp(16'h0101, 5));
    chk("t1_done_cyc", dcyc, t0 + 194);
    chk("t1_done", done0, 1);
    chk("t1_busy_low", busy0, 0);
    clearq();
    // same stream with a 3-cycle stall mid-word and a 1-cycle stall before the final beat
    go0(5, 1);
    chk("t2_done_drop", done0, 0);
    rec0(16'h0001, 5, 3, 8, 3);
    rec0(16'h0101, 5, 0, 15, 1);
    repeat (4) tick;
    chk("t2_nwr", qc.size(), 2);
    chk("t2_cyc0", qc[0], t0 + 100);
    chk("t2_data0", qd[0], rec_exp(16'h0001, 5));
    chk("t2_cyc1", qc[1], t0 + 197);
    chk("t2_addr1", qa[1], 1);
    chk("t2_data1", qd[1], rec_exp(16'h0101, 5));
    chk("t2_done_cyc", dcyc, t0 + 198);
    clearq();
    // reset after 3 of 6 words, then a clean single-record load
    go0(5, 0);
    word0(16'hFFFF, -1, 0); word0(16'hFFFF, -1, 0); word0(16'hFFFF, -1, 0);
    rst = 1; tick; rst = 0;
    chk("t4_busy", busy0, 0);
    chk("t4_done", done0, 0);
    tick;
    chk("t4_nowr", qc.size(), 0);
    go0(5, 0);
    rec0(16'h0201, 5, -1, -1, 0);
    repeat (3) tick;
    chk("t4_nwr", qc.size(), 1);
    chk("t4_cyc", qc[0], t0 + 97);
    chk("t4_addr", qa[0], 0);
    chk("t4_data", qd[0], rec_exp(16'h0201, 5));
    chk("t4_done_cyc", dcyc, t0 + 98);
    clearq();
    // restart from DONE with three two-word records
    go0(1, 2);
    chk("t6_done_drop", done0, 0);
    chk("t6_busy", busy0, 1);
    rec0(16'h0301, 1, -1, -1, 0);
    rec0(16'h0401, 1, -1, -1, 0);
    rec0(16'h0501, 1, -1, -1, 0);
    repeat (3) tick;
    chk("t6_nwr", qc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_cyc%0d", i), qc[i], t0 + 33 + 32 * i);
      chk($sformatf("t6_addr%0d", i), qa[i], i);
      chk($sformatf("t6_data%0d", i), qd[i], rec_exp(16'h0301 + 16'(i * 256), 1));
    end
    chk("t6_done_cyc", dcyc, t0 + 98);
    chk("t6_done", done0, 1);
    clearq();
    // 4 lanes, MSB-first, single one-word record
    start1 = 1; feat1 = 0; dp1 = 0; t0 = ec; tick; start1 = 0;
    v1 = 1;
    s1 = 4'hA; tick; s1 = 4'h5; tick; s1 = 4'hC; tick; s1 = 4'h3; tick;
    v1 = 0; repeat (3) tick;
    chk("t3_nwr", qc.size(), 1);
    chk("t3_cyc", qc[0], t0 + 5);
    chk("t3_addr", qa[0], 0);
    chk("t3_data", qd[0], 256'hA5C3);
    chk("t3_done_cyc", dcyc, t0 + 6);
    clearq();
    // feat above MAX_FEATURES clamps to 8 words; start during LOAD is ignored
    start2 = 1; feat2 = 15; dp2 = 0; t0 = ec; tick; start2 = 0;
    for (int k = 7; k >= 0; k--) word2(16'h0301 + 16'(k), k == 5);
    repeat (3) tick;
    chk("t5_nwr", qc.size(), 1);
    chk("t5_cyc", qc[0], t0 + 129);
    chk("t5_addr", qa[0], 0);
    chk("t5_data", qd[0], rec_exp(16'h0301, 7));
    chk("t5_done_cyc", dcyc, t0 + 130);
    chk("t5_busy", busy2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/serial_record_loader.md
# serial_record_loader

Parametrised serial-to-record loader for the regression engine's training-data path. It deserialises a 1..LANES-bit-per-cycle bitstream into WORD_WIDTH-bit words. It packs (feat+1) words per data point, with the y value plus features, into one record and issues a single-cycle write per record to the dataset memory. It generalises the fixed 16-bit, 1-bit-serial, LSB-first load with configurable word width, lane count, bit order and a valid strobe.

## Interface
- WORD_WIDTH, 16, bits per word; must be a multiple of LANES
- MAX_FEATURES, 15, maximum feature count; a record holds MAX_FEATURES+1 words
- ADDR_WIDTH, 12, record address / data_points width
- LANES, 1, serial bits accepted per beat
- MSB_FIRST, 0, 0 = LSB of each word arrives first; 1 = MSB first
- FW, $clog2(MAX_FEATURES+1), feat width (derived)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE and DONE
- feat  in  FW  feature count, latched on start
- data_points  in  ADDR_WIDTH  last record index, latched on start; records loaded = data_points+1
- S_valid  in  1  beat qualifier for S
- S  in  LANES  serial data beat
- wr_en  out  1  one-cycle record write strobe
- wr_addr  out  ADDR_WIDTH  record index
- wr_data  out  WORD_WIDTH*(MAX_FEATURES+1)  record; slot k = bits [k*WORD_WIDTH +: WORD_WIDTH]
- busy  out  1  high in LOAD
- done_  out  1  high in DONE

## Operation
- States: IDLE, LOAD, DONE.
- IDLE --start--> LOAD. Latch feat, clamped to MAX_FEATURES. Latch data_points. Clear the bit, word and record counters and the record buffer.
- LOAD: accept a beat each cycle with S_valid=1. When S_valid=0, all counters and buffers hold.
- Beat assembly:
  - MSB_FIRST=0: beat b (0-based within the word) lane l goes to word bit b*LANES+l.
  - MSB_FIRST=1: the word shift register shifts left by LANES with S entering the low LANES bits. The first beat therefore ends in the top bits.
- Each word is complete after WORD_WIDTH/LANES beats.
- Word order within a record: the first completed word goes to slot feat_l, the next to feat_l-1, down to slot 0. Slots above feat_l read zero.
- Record complete: after the beat that completes slot 0, assert wr_en for exactly one cycle with wr_addr = record index and the full record on wr_data. Then increment the record counter and clear the record buffer.
- The stream is back-to-back: a beat in the same cycle as wr_en belongs to the next record and is accepted.
- After the write of record data_points_l, go LOAD -> DONE. S is ignored.
- DONE: done_ held high. start re-enters LOAD with freshly latched feat and data_points, and done_ drops next cycle.
- start in LOAD is ignored. S_valid in IDLE/DONE is ignored.
- Arithmetic: bit counter width $clog2(WORD_WIDTH/LANES) (min 1), word counter FW bits, record counter ADDR_WIDTH bits. The counters never wrap within a load because data_points ≤ 2^ADDR_WIDTH-1.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done_=0, state IDLE, all counters 0.
- RST mid-LOAD: the partial word and record are discarded, no write is issued, and the state returns to IDLE on the next edge.
- Start cycle: the state changes at the edge sampling start. Beats are accepted from the following cycle.
- With continuous S_valid, one record takes (feat_l+1)*WORD_WIDTH/LANES beats.
- wr_en rises in the cycle after the completing beat is sampled (1-cycle latency). wr_data/wr_addr are valid only while wr_en=1.
- done_ and the busy fall occur in the cycle after the final wr_en.
- Total cycles from start edge to done_ high = (data_points+1)*(feat+1)*WORD_WIDTH/LANES + 2, with no stalls.

## Test plan
- Default params, feat=5, data_points=1, two records streamed LSB-first with words (slot5..slot0) 0x0006..0x0001 and 0x0106..0x0101 -> wr_en at addr 0 then 1. Slot k = 0x0001+k (and 0x0101+k). Slots 6..15 = 0. done_ high 2+192 cycles after start.
- Same stimulus with S_valid dropped for 3 cycles mid-word and 1 cycle on the final beat -> identical wr_data/wr_addr. wr_en and done_ are delayed by exactly 4 cycles.
- LANES=4, MSB_FIRST=1, feat=0, data_points=0, beats 0xA,0x5,0xC,0x3 -> single wr_en, addr 0, slot0 = 0xA5C3. done_ 6 cycles after start.
- Reset after 3 of 6 words of record 0, then restart and stream one full record -> no wr_en before the restart. The first write has addr 0 and contains only post-restart data.
- start pulsed during LOAD and feat=15 with MAX_FEATURES=7 -> the mid-load start has no effect. The feat=15 load is clamped to 8 words per record.
- Restart from DONE with data_points=2 -> done_ low the cycle after start. Three writes at addr 0,1,2, then done_ high again.
